// File: rtl/multi_channel_timer.sv
// multi_channel_timer
//
// Memory-mapped timer peripheral. A prescaler divides clk down to a periodic
// tick. The tick advances a free-running 32-bit TIME counter and decrements
// N_CH countdown channels. Each channel can be one-shot or periodic, and each
// one sets a sticky pending bit when it expires. The pending bits, masked by
// IRQ_EN, are OR-reduced into one level interrupt.
//
// Ports
//   clk    in   1       system clock
//   rst    in   1       asynchronous active-high reset
//   cs     in   1       bus select
//   we     in   1       write enable (qualified by cs)
//   addr   in   ADDR_W  word address
//   wdata  in   32      write data
//   rdata  out  32      registered read data, valid one cycle after cs & !we
//   timer  out  32      free-running tick count (TIME register)
//   tick   out  1       one-cycle pulse on each prescaler expiry
//   irq    out  1       |(PEND & IRQ_EN)
//
// Word-address map
//   0 TIME (RW)   1 PEND (W1C)   2 IRQ_EN (RW)   3 reserved
//   Channel i at 4*(i+1): +0 LOAD (RW), +1 COUNT (RO),
//                         +2 CTRL (RW, bit0 EN, bit1 PERIODIC), +3 reserved

module multi_channel_timer #(
    parameter int TICK_DIV = 100_000,
    parameter int N_CH     = 4,
    parameter int CNT_W    = 32,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [31:0]       timer,
    output logic              tick,
    output logic              irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = ADDR_W - 2;

    logic [PW-1:0]    presc_q, presc_d;
    logic [31:0]      time_q, time_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  irqEn_q, irqEn_d;
    logic [N_CH-1:0]  en_q, en_d;
    logic [N_CH-1:0]  per_q, per_d;
    logic [CNT_W-1:0] load_q [N_CH];
    logic [CNT_W-1:0] load_d [N_CH];
    logic [CNT_W-1:0] count_q [N_CH];
    logic [CNT_W-1:0] count_d [N_CH];
    logic [31:0]      rdata_q, rdata_d;

    logic [BW-1:0]    blk;
    logic [1:0]       sub;
    logic             wrEn;
    logic             rdEn;
    logic [N_CH-1:0]  chSel;

    // The upper address bits select a block: block 0 holds the global
    // registers and block i+1 holds channel i. The low two bits select the
    // word within the block.
    assign blk  = addr[ADDR_W-1:2];
    assign sub  = addr[1:0];
    assign wrEn = cs & we;
    assign rdEn = cs & ~we;

    assign tick  = (presc_q == PW'(TICK_DIV - 1));
    assign timer = time_q;
    assign rdata = rdata_q;
    assign irq   = |(pend_q & irqEn_q);

    // The prescaler wraps on its last count. Bus traffic never touches it.
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_comb begin
        chSel = '0;
        for (int i = 0; i < N_CH; i++) begin
            chSel[i] = (blk == BW'(i + 1));
        end
    end

    // A bus write to TIME takes priority over the tick increment in the same
    // cycle.
    always_comb begin
        time_d = time_q;
        if (wrEn && blk == '0 && sub == 2'd0) begin
            time_d = wdata;
        end else if (tick) begin
            time_d = time_q + 32'd1;
        end
    end

    // Channel and pending logic. The W1C clear is applied first and the expiry
    // sets are ORed in after it, so an expiry wins over a clear in the same
    // cycle. A CTRL write masks that channel's tick in the same cycle.
    always_comb begin
        pend_d  = pend_q;
        irqEn_d = irqEn_q;
        en_d    = en_q;
        per_d   = per_q;
        for (int i = 0; i < N_CH; i++) begin
            load_d[i]  = load_q[i];
            count_d[i] = count_q[i];
        end

        if (wrEn && blk == '0 && sub == 2'd1) begin
            pend_d = pend_q & ~wdata[N_CH-1:0];
        end
        if (wrEn && blk == '0 && sub == 2'd2) begin
            irqEn_d = wdata[N_CH-1:0];
        end

        for (int i = 0; i < N_CH; i++) begin
            if (wrEn && chSel[i] && sub == 2'd0) begin
                load_d[i] = wdata[CNT_W-1:0];
            end
            if (wrEn && chSel[i] && sub == 2'd2) begin
                en_d[i]  = wdata[0];
                per_d[i] = wdata[1];
                if (wdata[0]) begin
                    count_d[i] = load_q[i];
                end
            end else if (tick && en_q[i]) begin
                // A count of 0 or 1 expires, so a LOAD of 0 behaves like a LOAD of 1.
                if (count_q[i] <= CNT_W'(1)) begin
                    pend_d[i] = 1'b1;
                    if (per_q[i]) begin
                        count_d[i] = load_q[i];
                    end else begin
                        count_d[i] = '0;
                        en_d[i]    = 1'b0;
                    end
                end else begin
                    count_d[i] = count_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Read mux. It sees the pre-update register contents. Anything unmapped
    // or reserved reads as zero.
    always_comb begin
        rdata_d = '0;
        if (blk == '0) begin
            case (sub)
                2'd0:    rdata_d = time_q;
                2'd1:    rdata_d = 32'(pend_q);
                2'd2:    rdata_d = 32'(irqEn_q);
                default: rdata_d = '0;
            endcase
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (chSel[i]) begin
                    case (sub)
                        2'd0:    rdata_d = 32'(load_q[i]);
                        2'd1:    rdata_d = 32'(count_q[i]);
                        2'd2:    rdata_d = {30'd0, per_q[i], en_q[i]};
                        default: rdata_d = '0;
                    endcase
                end
            end
        end
    end

    // State registers. The reset is asynchronous and clears everything.
    // rdata only updates on a read cycle and otherwise holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            time_q  <= '0;
            pend_q  <= '0;
            irqEn_q <= '0;
            en_q    <= '0;
            per_q   <= '0;
            rdata_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                load_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
            pend_q  <= pend_d;
            irqEn_q <= irqEn_d;
            en_q    <= en_d;
            per_q   <= per_d;
            if (rdEn) begin
                rdata_q <= rdata_d;
            end
            for (int i = 0; i < N_CH; i++) begin
                load_q[i]  <= load_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

endmodule
